// File: rtl/bist_session_controller.sv
// Scan BIST session sequencer: shift/capture windows, serial MISR unload,
// and golden signature compare.
module bist_session_controller #(
  parameter int CHAIN_LEN   = 4,
  parameter int NUM_VECTORS = 32,
  parameter int SIGN_WIDTH  = 16,
  parameter logic [SIGN_WIDTH-1:0] GOLDEN = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGN,
  output logic                  CUT_RST,
  output logic                  SE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [SIGN_WIDTH-1:0] SIGN_CAPT
);

  localparam int MAXC = (CHAIN_LEN > SIGN_WIDTH) ? CHAIN_LEN : SIGN_WIDTH;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int VW   = $clog2(NUM_VECTORS + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CUTRST,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]         r_cnt;
  logic [VW-1:0]         r_vec;
  logic                  r_cut_rst;
  logic                  r_se;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [SIGN_WIDTH-1:0] r_capt;

  logic                  w_sh_last;
  logic                  w_un_last;
  logic                  w_vec_last;
  logic [SIGN_WIDTH-1:0] w_capt;
  logic [SIGN_WIDTH-1:0] w_final;

  assign w_sh_last  = (r_cnt == CW'(CHAIN_LEN - 1));
  assign w_un_last  = (r_cnt == CW'(SIGN_WIDTH - 1));
  assign w_vec_last = (r_vec == VW'(NUM_VECTORS));
  assign w_capt     = r_capt | (SIGN_WIDTH'(SIGN) << r_cnt);
  assign w_final    = (r_state == S_UNLOAD) ? w_capt : r_capt;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (START) w_next = S_CUTRST;
      S_DONE:    if (START) w_next = S_CUTRST;
      S_CUTRST:  w_next = S_SHIFT;
      S_SHIFT:   if (w_sh_last) w_next = S_CAPTURE;
      S_CAPTURE: w_next = w_vec_last ? S_UNLOAD : S_SHIFT;
      S_UNLOAD:  if (w_un_last) w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt     <= '0;
      r_vec     <= '0;
      r_cut_rst <= 1'b0;
      r_se      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_capt    <= '0;
    end else begin
      r_cut_rst <= (w_next == S_CUTRST);
      r_se      <= (w_next == S_SHIFT) || (w_next == S_UNLOAD);
      r_busy    <= (w_next == S_CUTRST) || (w_next == S_SHIFT) ||
                   (w_next == S_CAPTURE) || (w_next == S_UNLOAD);
      r_done    <= (w_next == S_DONE);
      r_pass    <= (w_next == S_DONE) && (w_final == GOLDEN);
      case (r_state)
        S_SHIFT:   r_cnt <= w_sh_last ? '0 : r_cnt + CW'(1);
        S_CAPTURE: begin
          r_vec <= r_vec + VW'(1);
          r_cnt <= '0;
        end
        S_UNLOAD:  begin
          r_cnt  <= r_cnt + CW'(1);
          r_capt <= w_capt;
        end
        default: ;
      endcase
      if (w_next == S_CUTRST) begin
        r_cnt  <= '0;
        r_vec  <= '0;
        r_capt <= '0;
      end
    end
  end

  assign CUT_RST   = r_cut_rst;
  assign SE        = r_se;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign SIGN_CAPT = r_capt;

endmodule

// File: tb/tb_bist_session_controller.sv
// Bench for bist_session_controller: two parameter sets, queued
// expectations popped by a DONE monitor.
module tb_bist_session_controller;

  localparam logic [15:0] GOLD = 16'hA5C3;

  typedef struct {
    int          cyc;
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst     [2];
  logic        start   [2];
  logic        sign    [2];
  logic        cut_rst [2];
  logic        se      [2];
  logic        busy    [2];
  logic        done    [2];
  logic        pass    [2];
  logic [15:0] capt    [2];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cr  [2];
  int   cap [2];
  logic pdone [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t me;
  logic last_pass;

  bist_session_controller #(
    .CHAIN_LEN(4), .NUM_VECTORS(32), .SIGN_WIDTH(16), .GOLDEN(GOLD)
  ) dut_a (
    .CLK(CLK), .RST(rst[0]), .START(start[0]), .SIGN(sign[0]),
    .CUT_RST(cut_rst[0]), .SE(se[0]), .BUSY(busy[0]), .DONE(done[0]),
    .PASS(pass[0]), .SIGN_CAPT(capt[0])
  );

  bist_session_controller #(
    .CHAIN_LEN(8), .NUM_VECTORS(4), .SIGN_WIDTH(16), .GOLDEN(GOLD)
  ) dut_b (
    .CLK(CLK), .RST(rst[1]), .START(start[1]), .SIGN(sign[1]),
    .CUT_RST(cut_rst[1]), .SE(se[1]), .BUSY(busy[1]), .DONE(done[1]),
    .PASS(pass[1]), .SIGN_CAPT(capt[1])
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int cl(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int nv(int d);
    return (d == 0) ? 32 : 4;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (cut_rst[d] === 1'b1) begin
        cr[d]++;
        chk("cutrst_outs", {29'd0, done[d], pass[d], busy[d]}, 32'd1);
      end
      if (busy[d] === 1'b1 && se[d] === 1'b0 && cut_rst[d] === 1'b0)
        cap[d]++;
      if (done[d] === 1'b1 && pdone[d] !== 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: dut %0d at cycle %0d", d, cyc);
        end else begin
          if (d == 0) me = q0.pop_front();
          else        me = q1.pop_front();
          chk("done_cycle", cyc, me.cyc);
          chk("sign_capt", {16'd0, capt[d]}, {16'd0, me.sig});
          chk("pass", {31'd0, pass[d]}, {31'd0, me.pass});
          chk("cut_rst_count", cr[d], 1);
          chk("capture_count", cap[d], nv(d) + 1);
          chk("done_se_busy", {30'd0, se[d], busy[d]}, 32'd0);
        end
        cr[d]  = 0;
        cap[d] = 0;
      end
      pdone[d] = done[d];
    end
  end

  task automatic session(int d, logic [15:0] word, int flip,
                         bit disturb, int abort_at);
    int   k, u, tot;
    exp_t e;
    @(posedge CLK); #1;
    k = cyc + 1;
    start[d] = 1'b1;
    u   = k + 1 + (nv(d) + 1) * (cl(d) + 1);
    tot = u + 16;
    e.cyc  = tot;
    e.sig  = word;
    if (flip >= 0) e.sig[flip] = ~e.sig[flip];
    e.pass = (e.sig == GOLD);
    last_pass = e.pass;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge CLK); #1;
    start[d] = 1'b0;
    while (cyc < tot + 2) begin
      start[d] = disturb && (cyc == k + 49 || cyc == k + 169);
      if (cyc >= u && cyc < u + 16) sign[d] = e.sig[cyc - u];
      else                          sign[d] = 1'($urandom);
      if (abort_at >= 0 && cyc == u + abort_at) begin
        rst[d] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_outs",
            {9'd0, cut_rst[d], se[d], busy[d], done[d], pass[d], capt[d]},
            32'd0);
        @(posedge CLK); #1;
        rst[d] = 1'b0;
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        cr[d]  = 0;
        cap[d] = 0;
        return;
      end
      @(posedge CLK); #1;
    end
    if ((d == 0 && q0.size() != 0) || (d == 1 && q1.size() != 0)) begin
      total++;
      bad++;
      $display("FAIL done_timeout: dut %0d no DONE by cycle %0d", d, cyc);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  task automatic hold_check(int d);
    repeat (3) @(negedge CLK);
    chk("done_hold", {30'd0, done[d], pass[d]}, {30'd0, 1'b1, last_pass});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b1;
      start[d] = 1'b1;
      sign[d]  = 1'b0;
      cr[d]    = 0;
      cap[d]   = 0;
      pdone[d] = 1'b0;
    end
    repeat (2) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++)
        chk("reset_outs",
            {10'd0, cut_rst[d], se[d], busy[d], done[d], pass[d], capt[d]},
            32'd0);
    end
    @(posedge CLK); #1;
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b0;
      start[d] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("reset_no_cutrst", cr[d], 0);
      chk("reset_idle", {30'd0, busy[d], se[d]}, 32'd0);
    end

    session(0, GOLD, -1, 1'b0, -1);
    hold_check(0);
    session(0, GOLD, 7, 1'b0, -1);
    hold_check(0);
    session(0, 16'($urandom), -1, 1'b1, -1);
    hold_check(0);
    session(0, 16'($urandom), -1, 1'b0, 2);
    session(0, GOLD, -1, 1'b0, -1);
    hold_check(0);
    session(0, 16'($urandom), 0, 1'b0, -1);

    session(1, GOLD, -1, 1'b0, -1);
    hold_check(1);
    session(1, GOLD, 15, 1'b0, -1);
    session(1, 16'($urandom), -1, 1'b1, -1);
    session(1, 16'($urandom), -1, 1'b0, 0);
    session(1, GOLD, -1, 1'b0, -1);
    hold_check(1);

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_session_controller.md
# bist_session_controller

Sequencer and signature checker that drives a scan-based BIST session on the CUT-with-MISR block from the initiator side. Each vector is a scan-enable window of CHAIN_LEN shift cycles followed by one capture cycle, repeated NUM_VECTORS+1 times; the extra window flushes the final response into the MISR. The block then unloads the serial MISR signature, compares it with a golden value, and reports pass/fail to the system test logic.

## Interface
- CHAIN_LEN, 4: scan-chain length; SE shift cycles per vector (≥1)
- NUM_VECTORS, 32: pseudo-random vectors per session (≥1)
- SIGN_WIDTH, 16: MISR signature width in bits (≥2)
- GOLDEN, 16'h0000: expected signature, SIGN_WIDTH bits

- CLK  in  1  sole clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  session request, sampled only in IDLE or DONE
- SIGN  in  1  serial signature bit from the CUT's MISR
- CUT_RST  out  1  one-cycle reset to the CUT (reseeds LFSR, clears MISR and scan regs)
- SE  out  1  scan enable to the CUT
- BUSY  out  1  high from START acceptance until DONE state entered
- DONE  out  1  session complete; PASS and SIGN_CAPT valid
- PASS  out  1  SIGN_CAPT == GOLDEN; valid only while DONE=1
- SIGN_CAPT  out  SIGN_WIDTH  captured signature, bit 0 = first bit unloaded

## Operation
- All outputs are registered. Reset values: CUT_RST=0, SE=0, BUSY=0, DONE=0, PASS=0, SIGN_CAPT=0. State is IDLE.
- States: IDLE, CUTRST, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: if START=1, go to CUTRST, set BUSY=1, and clear SIGN_CAPT.
- CUTRST: one cycle with CUT_RST=1 and SE=0. Clear the vector counter, then go to SHIFT.
- SHIFT: SE=1 for exactly CHAIN_LEN cycles (shift counter 0..CHAIN_LEN-1), then go to CAPTURE.
- CAPTURE: SE=0 for one cycle. Increment the vector counter. If the counter has reached NUM_VECTORS+1 windows, go to UNLOAD; otherwise go to SHIFT.
- UNLOAD: SE=1 for SIGN_WIDTH cycles. In the i-th UNLOAD cycle (i = 0..SIGN_WIDTH-1), SIGN is sampled into SIGN_CAPT[i]. After the last bit, go to DONE.
- DONE: DONE=1, BUSY=0, SE=0, PASS=(SIGN_CAPT==GOLDEN). Hold until START=1, which behaves as START in IDLE (DONE and PASS drop the cycle CUTRST is entered).
- START while BUSY=1 is ignored, with no restart and no error.
- RST=1 in any state returns to IDLE with all reset values on the next edge. This includes mid-SHIFT, mid-UNLOAD, and a simultaneous START. A partial SIGN_CAPT is discarded.
- Counter widths: vector counter clog2(NUM_VECTORS+2), shift/unload counter clog2(max(CHAIN_LEN, SIGN_WIDTH)+1). No wrap occurs within a session. Counters reset on entering CUTRST.

## Timing
- START sampled high at edge k puts CUTRST in effect for cycle k→k+1.
- The first SHIFT cycle begins at edge k+1.
- The scan phase lasts (NUM_VECTORS+1)·(CHAIN_LEN+1) cycles; 165 at defaults.
- UNLOAD starts at edge k+1+165 and lasts SIGN_WIDTH cycles.
- DONE=1 and PASS are valid from edge k+1+(NUM_VECTORS+1)(CHAIN_LEN+1)+SIGN_WIDTH, which is k+182 at defaults.
- SIGN must be stable around each rising edge during UNLOAD. The CUT updates SIGN after the edge on which SE shifts its MISR.
- SE pattern per window: CHAIN_LEN high cycles, then 1 low cycle. There are exactly NUM_VECTORS+1 low capture pulses per session, excluding CUTRST.

## Test plan
- Reset: hold RST for 2 cycles with START=1. All outputs read 0 and the state stays IDLE; no CUT_RST pulse occurs.
- Golden pass: set GOLDEN=16'hA5C3. The bench drives SIGN = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first) during UNLOAD. Expect DONE=1 at START+182 cycles, SIGN_CAPT=16'hA5C3, PASS=1, and 33 SE capture pulses counted.
- Single-bit error: same as golden pass, but flip SIGN at unload bit 7. Expect SIGN_CAPT=16'hA543 and PASS=0.
- START during run: pulse START at cycles 50 and 170 after acceptance. Expect no restart, no extra CUT_RST, and DONE still at +182.
- Mid-session reset: assert RST at the 3rd UNLOAD cycle. Next edge shows IDLE, SE=0, BUSY=0, SIGN_CAPT=0. A new START then completes a full session normally.
- Back-to-back sessions and parameters: START in DONE drops DONE/PASS on the next edge and reruns. Repeat with CHAIN_LEN=8 and NUM_VECTORS=4, expecting DONE at +1+45+16 = +62 cycles.
